// File: rtl/restador_bcd_serial_pkg.sv
// rtl/restador_bcd_serial_pkg.sv - shared constants and FSM states for the serial BCD subtractor
// Contents: BCD digit width, decimal radix, largest legal digit, FSM state enum,
//           and a digit validity helper.
package restador_bcd_serial_pkg;

  localparam int              BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_DIEZ = 4'd10;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESTA = 2'd1,
    COMPL = 2'd2,
    FIN   = 2'd3
  } estado_t;

  function automatic logic digito_invalido(input logic [BCD_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/restador_digito_bcd.sv
// rtl/restador_digito_bcd.sv - combinational one-digit BCD subtract with borrow correction
// Ports: a, b        - BCD digits (a - b)
//        borrow_in   - incoming borrow
//        d           - corrected result digit
//        borrow_out  - 1 when the raw difference went negative
module restador_digito_bcd
  import restador_bcd_serial_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] d,
  output logic             borrow_out
);

  logic [BCD_W:0] diff;

  always_comb begin
    // One extra bit acts as the sign of a 5-bit two's complement difference.
    diff       = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, borrow_in};
    borrow_out = diff[BCD_W];
    // Adding ten modulo 16 to the low nibble yields the decimal digit.
    d          = diff[BCD_W-1:0] + (diff[BCD_W] ? BCD_DIEZ : '0);
  end

endmodule

// File: rtl/restador_bcd_serial.sv
// rtl/restador_bcd_serial.sv - digit-serial BCD subtractor returning sign and magnitude
// Ports: clk, rst (async, active-high)
//        start     - begin an operation (only honoured in IDLE)
//        A, B      - packed BCD operands, digit 0 in bits [3:0]
//        busy      - operation in progress
//        done      - one-cycle result-valid pulse
//        Y         - |A-B| in packed BCD
//        negativo  - 1 when A<B
//        error     - operand held a digit greater than 9
module restador_bcd_serial
  import restador_bcd_serial_pkg::*;
#(
  parameter int DIGITOS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BCD_W*DIGITOS-1:0] A,
  input  logic [BCD_W*DIGITOS-1:0] B,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_W*DIGITOS-1:0] Y,
  output logic                     negativo,
  output logic                     error
);

  localparam int                 W      = BCD_W * DIGITOS;
  localparam int                 IDX_W  = 4;
  localparam logic [IDX_W-1:0]   ULTIMO = IDX_W'(DIGITOS - 1);

  estado_t          state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, r_q, r_d, y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d, neg_q, neg_d;
  logic             negativo_q, negativo_d, error_q, error_d, done_q, done_d;

  logic [BCD_W-1:0] op_a, op_b, dig_d;
  logic             dig_borrow;
  logic             entrada_invalida;

  // In COMPL the stored result is subtracted from zero (ten's complement).
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        op_a = (state_q == COMPL) ? '0 : a_q[i*BCD_W +: BCD_W];
        op_b = (state_q == COMPL) ? r_q[i*BCD_W +: BCD_W] : b_q[i*BCD_W +: BCD_W];
      end
    end
  end

  restador_digito_bcd u_digito (
    .a          (op_a),
    .b          (op_b),
    .borrow_in  (borrow_q),
    .d          (dig_d),
    .borrow_out (dig_borrow)
  );

  always_comb begin
    entrada_invalida = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (digito_invalido(A[i*BCD_W +: BCD_W]) || digito_invalido(B[i*BCD_W +: BCD_W]))
        entrada_invalida = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    err_d      = err_q;
    neg_d      = neg_q;
    y_d        = y_q;
    negativo_d = negativo_q;
    error_d    = error_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          r_d      = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          neg_d    = 1'b0;
          err_d    = entrada_invalida;
          state_d  = entrada_invalida ? FIN : RESTA;
        end
      end
      RESTA, COMPL: begin
        for (int i = 0; i < DIGITOS; i++) begin
          if (idx_q == IDX_W'(i)) r_d[i*BCD_W +: BCD_W] = dig_d;
        end
        borrow_d = dig_borrow;
        idx_d    = idx_q + 1'b1;
        if (idx_q == ULTIMO) begin
          idx_d = '0;
          if (state_q == COMPL) begin
            neg_d   = 1'b1;
            state_d = FIN;
          end else if (dig_borrow) begin
            // A<B: the digits hold the ten's complement of |A-B|.
            borrow_d = 1'b0;
            state_d  = COMPL;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done_d     = 1'b1;
        y_d        = err_q ? '0 : r_q;
        negativo_d = err_q ? 1'b0 : neg_q;
        error_d    = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      err_q      <= 1'b0;
      neg_q      <= 1'b0;
      y_q        <= '0;
      negativo_q <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      err_q      <= err_d;
      neg_q      <= neg_d;
      y_q        <= y_d;
      negativo_q <= negativo_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == RESTA) || (state_q == COMPL);
  assign done     = done_q;
  assign Y        = y_q;
  assign negativo = negativo_q;
  assign error    = error_q;

endmodule

// File: doc/restador_bcd_serial.md
RESTADOR_BCD_SERIAL -- requirements
Module: restador_bcd_serial

Interface
REQ-001 SHALL have parameter DIGITOS, default 3, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A, input, 4*DIGITOS bits: minuend, packed BCD, digit 0 in A[3:0].
REQ-006 SHALL have port B, input, 4*DIGITOS bits: subtrahend, same packing as A.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress (RESTA or COMPL).
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port Y, output, 4*DIGITOS bits: magnitude |A-B| in packed BCD.
REQ-010 SHALL have port negativo, output, 1 bit: sign of the result, 1 when A<B.
REQ-011 SHALL have port error, output, 1 bit: set when any captured digit of A or B is greater than 9.

Function
REQ-012 SHALL implement FSM states IDLE, RESTA, COMPL, FIN.
REQ-013 In IDLE with start=1, SHALL capture A and B into internal registers, clear the digit index and the borrow, and go to RESTA; if any captured digit is >9, SHALL instead go to FIN with error=1, Y=0 and negativo=0.
REQ-014 In RESTA, SHALL process one digit per cycle, LSD first: d = a_i - b_i - borrow (5-bit signed); if d<0, write d+10 and set borrow=1, otherwise write d and set borrow=0.
REQ-015 After digit DIGITOS-1 in RESTA: if the final borrow is 0, SHALL go to FIN; if it is 1, SHALL clear the borrow and index and go to COMPL.
REQ-016 In COMPL, SHALL replace each result digit, LSD first, one per cycle, with 0 - r_i - borrow using the same correction rule (ten's complement), then go to FIN with negativo=1.
REQ-017 In FIN, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Y, negativo and error SHALL update only in FIN and hold their values until the next FIN.
REQ-019 Latency from the start-sampling edge to done high SHALL be DIGITOS+1 cycles for A>=B, 2*DIGITOS+1 cycles for A<B, and 1 cycle for an error.
REQ-020 start SHALL be ignored while busy=1 or in FIN; A and B SHALL be don't-care after capture.
REQ-021 A==B SHALL give Y=0 with negativo=0.
REQ-022 When A<B, 0-difference SHALL never produce negativo=1 with Y=0.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, busy=0, done=0, Y=0, negativo=0, error=0, and clear the operand registers, index and borrow.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be serviced normally.

Structure
REQ-025 A shared package SHALL hold the BCD digit width constant (4), the constant 10, and the FSM state enumeration.
REQ-026 The one-digit borrow-corrected subtract SHALL be a sub-module restador_digito_bcd (inputs a, b, borrow_in; outputs d, borrow_out), purely combinational, used by both RESTA and COMPL.

Verification (DIGITOS=3)
REQ-027 A=0x345, B=0x123 -> done 4 cycles after start, Y=0x222, negativo=0, error=0.
REQ-028 A=0x123, B=0x345 -> done 7 cycles after start, Y=0x222, negativo=1.
REQ-029 A=0x100, B=0x001 -> Y=0x099, negativo=0; A=0x000, B=0x999 -> Y=0x999, negativo=1; A=B=0x555 -> Y=0x000, negativo=0.
REQ-030 A=0x1A3, B=0x001 -> done 1 cycle after start, error=1, Y=0x000.
REQ-031 start pulsed again 2 cycles into a 0x345-0x123 run with A=0x999 -> ignored; single done with Y=0x222.
REQ-032 rst asserted 2 cycles into a run -> outputs immediately zero, no done; a new start with 0x500-0x250 -> Y=0x250, negativo=0.
